// File: rtl/video_timing_gen.sv
// Free-running video timing generator with vreset re-phasing and lock tracking.
// All outputs are registered and decoded from the counter position one cycle earlier.
module video_timing_gen #(
    parameter int   H_ACTIVE    = 720,
    parameter int   H_FP        = 12,
    parameter int   H_SYNC      = 64,
    parameter int   H_BP        = 68,
    parameter int   V_ACTIVE    = 576,
    parameter int   V_FP        = 5,
    parameter int   V_SYNC      = 5,
    parameter int   V_BP        = 39,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   LOCK_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vreset,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        sof,
    output logic        locked
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic [3:0]  fcnt;
    lock_state_t state;
    logic        h_end;
    logic        frame_end;

    always_comb begin
        h_end     = (hcnt == H_LAST);
        frame_end = h_end && (vcnt == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt   <= '0;
            vcnt   <= '0;
            fcnt   <= '0;
            state  <= UNLOCKED;
            hs     <= ~HS_POL;
            vs     <= ~VS_POL;
            de     <= 1'b0;
            x      <= '0;
            y      <= '0;
            sof    <= 1'b0;
            locked <= 1'b0;
        end else begin
            hs     <= ((hcnt >= HS_START) && (hcnt < HS_END)) ? HS_POL : ~HS_POL;
            vs     <= ((vcnt >= VS_START) && (vcnt < VS_END)) ? VS_POL : ~VS_POL;
            de     <= (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
            x      <= hcnt;
            y      <= vcnt;
            sof    <= (hcnt == '0) && (vcnt == '0);
            // Registered from the pre-edge state so a lock change lines up with sof.
            locked <= (state == LOCKED);

            if (vreset) begin
                hcnt <= '0;
                vcnt <= '0;
            end else if (h_end) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 11'd1;
            end else begin
                hcnt <= hcnt + 12'd1;
            end

            // An in-phase vreset neither counts a frame nor disturbs the lock.
            if (vreset && !frame_end) begin
                fcnt  <= '0;
                state <= UNLOCKED;
            end else if (!vreset && frame_end && (fcnt != LOCK_N)) begin
                fcnt <= fcnt + 4'd1;
                if (fcnt + 4'd1 == LOCK_N)
                    state <= LOCKED;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized scoreboard bench for video_timing_gen using small timings and a
// linear frame-position reference model.
module tb_video_timing_gen;

    localparam int   HA = 10, HFP = 3, HSW = 4, HBP = 2;
    localparam int   VA = 6,  VFP = 2, VSW = 2, VBP = 1;
    localparam int   LOCK = 3;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int   HT = HA + HFP + HSW + HBP;
    localparam int   VT = VA + VFP + VSW + VBP;
    localparam int   F  = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [10:0] y;
        logic        sof;
        logic        locked;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vreset = 1'b0;
    logic        hs, vs, de, sof, locked;
    logic [11:0] x;
    logic [10:0] y;

    out_t exp_q[$];
    int   tests = 0;
    int   failures = 0;

    // Reference model: linear position within the frame, frames since last disturbance.
    int   m_pos = 0;
    int   m_frames = 0;
    logic m_lock = 1'b0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .LOCK_FRAMES(LOCK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vreset(vreset),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .sof(sof), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic r, input logic v);
        out_t e;
        int   h, l;
        @(negedge clk);
        reset_n = r;
        vreset  = v;
        if (!r) begin
            e.hs = ~HSP; e.vs = ~VSP; e.de = 1'b0; e.x = '0; e.y = '0;
            e.sof = 1'b0; e.locked = 1'b0;
            m_pos = 0; m_frames = 0; m_lock = 1'b0;
        end else begin
            h = m_pos % HT;
            l = m_pos / HT;
            e.hs     = (h >= HA + HFP && h < HA + HFP + HSW) ? HSP : ~HSP;
            e.vs     = (l >= VA + VFP && l < VA + VFP + VSW) ? VSP : ~VSP;
            e.de     = (h < HA) && (l < VA);
            e.x      = 12'(h);
            e.y      = 11'(l);
            e.sof    = (m_pos == 0);
            e.locked = m_lock;
            if (v) begin
                if (m_pos != F - 1) begin
                    m_lock = 1'b0;
                    m_frames = 0;
                end
                m_pos = 0;
            end else begin
                if (m_pos == F - 1) begin
                    if (m_frames < LOCK) m_frames++;
                    if (m_frames >= LOCK) m_lock = 1'b1;
                end
                m_pos = (m_pos + 1) % F;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    always @(posedge clk) begin
        out_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{hs, vs, de, x, y, sof, locked};
            tests++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs @%0t: got hs=%b vs=%b de=%b x=%0d y=%0d sof=%b locked=%b, required hs=%b vs=%b de=%b x=%0d y=%0d sof=%b locked=%b",
                         $time, a.hs, a.vs, a.de, a.x, a.y, a.sof, a.locked,
                         e.hs, e.vs, e.de, e.x, e.y, e.sof, e.locked);
            end
        end
    end

    initial begin
        // Power-up reset, then free run long enough to lock.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        run((LOCK + 1) * F + 7);

        // Out-of-phase re-phase requests at random positions.
        for (int k = 0; k < 4; k++) begin
            run($urandom_range(1, F - 3));
            if (m_pos == F - 1) cycle(1'b1, 1'b0);
            cycle(1'b1, 1'b1);
            run(LOCK * F + 5);
        end

        // In-phase request while locked.
        for (int i = 0; i < F && m_pos != F - 1; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        run(2 * F);

        // vreset together with reset, then a 3-cycle vreset pulse.
        run(37);
        cycle(1'b0, 1'b1);
        run(LOCK * F + 3);
        run(50);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        run(LOCK * F + 10);

        // Mixed random traffic with occasional aligned requests and mid-frame resets.
        for (int i = 0; i < 6000; i++) begin
            logic r, v;
            r = ($urandom_range(0, 1499) != 0);
            v = ($urandom_range(0, 399) == 0) ||
                ((m_pos == F - 1) && ($urandom_range(0, 2) == 0));
            cycle(r, v);
        end
        run(LOCK * F + 5);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
